riscv_wbuf_fwd: RTL and testbench

Parametrised posted-write buffer between the core data-memory interface (upstream) and the data cache/BIU (downstream). Writes are acknowledged on acceptance and drained in order. Reads may overtake buffered writes unless they hit a buffered address; a hit is served by store-to-load forwarding or stalled until it drains. Optional write merging and an explicit drain (fence) handshake are provided.

---
 rtl/riscv_wbuf_fwd.sv | 183 ++++++++++++++++++
 tb/tb_riscv_wbuf_fwd.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wbuf_fwd.sv
// Posted-write buffer between the core data port and the cache/BIU: in-order
// drain, overtaking reads, store-to-load forwarding, write merging and fences.
module riscv_wbuf_fwd #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int FORWARD = 1,
  parameter int MERGE   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_req_i,
  input  logic              up_we_i,
  input  logic [XLEN-1:0]   up_adr_i,
  input  logic [XLEN/8-1:0] up_be_i,
  input  logic [XLEN-1:0]   up_d_i,
  output logic [XLEN-1:0]   up_q_o,
  output logic              up_ack_o,
  output logic              up_err_o,
  output logic              dn_req_o,
  output logic              dn_we_o,
  output logic [XLEN-1:0]   dn_adr_o,
  output logic [XLEN/8-1:0] dn_be_o,
  output logic [XLEN-1:0]   dn_d_o,
  input  logic [XLEN-1:0]   dn_q_i,
  input  logic              dn_ack_i,
  input  logic              dn_err_i,
  input  logic              drain_i,
  output logic              drain_done_o,
  output logic              wr_err_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int PW = $clog2(DEPTH);

  // Downstream port: idle, draining the head entry, or passing a read through.
  // dn_req_o is high in S_WR/S_RD and drops the cycle after dn_ack_i.
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_e;
  state_e state_q, state_d;

  logic [XLEN-1:0]  adr_q [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];
  logic [BW-1:0]    be_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q, count_d;
  logic             fwd_ack_q;
  logic [XLEN-1:0]  fwd_dat_q;
  logic             wr_err_q, drain_done_q, drain_fired_q;

  logic             hit;
  logic [PW-1:0]    hit_idx, scan_idx, newest_idx;
  logic             merge_ok, wr_req, rd_req, wr_accept, push, merge_wr, pop;
  logic             fwd_go, rd_issue, full, empty, drain_cond;
  logic [XLEN-1:0]  mrg_dat;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Scan oldest to newest so the last match is the newest hitting entry.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (vld_q[scan_idx] && (adr_q[scan_idx][XLEN-1:OW] == up_adr_i[XLEN-1:OW])) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign newest_idx = tail_q - PW'(1);
  assign pop        = (state_q == S_WR) && dn_ack_i;
  assign merge_ok   = (MERGE != 0) && up_we_i && vld_q[newest_idx] &&
                      (adr_q[newest_idx][XLEN-1:OW] == up_adr_i[XLEN-1:OW]) &&
                      !((state_q == S_WR) && (newest_idx == head_q));
  assign wr_req     = up_req_i && up_we_i && !drain_i && !rst_i;
  assign rd_req     = up_req_i && !up_we_i && !drain_i && !rst_i;
  // A slot freed by a pop this cycle can take the incoming write.
  assign wr_accept  = wr_req && (merge_ok || !full || pop);
  assign push       = wr_accept && !merge_ok;
  assign merge_wr   = wr_accept && merge_ok;
  assign fwd_go     = (FORWARD != 0) && rd_req && hit && !fwd_ack_q &&
                      ((be_q[hit_idx] & up_be_i) == up_be_i);
  assign rd_issue   = rd_req && !hit && !fwd_ack_q;
  assign drain_cond = drain_i && empty && (state_q == S_IDLE) && !drain_fired_q;

  always_comb begin
    mrg_dat = dat_q[newest_idx];
    for (int b = 0; b < BW; b++) begin
      if (up_be_i[b]) mrg_dat[b*8 +: 8] = up_d_i[b*8 +: 8];
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rd_issue)           state_d = S_RD;
        else if (count_q != '0) state_d = S_WR;
      end
      S_WR:    if (dn_ack_i) state_d = S_IDLE;
      S_RD:    if (dn_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dn_req_o = (state_q != S_IDLE);
    dn_we_o  = (state_q == S_WR);
    dn_adr_o = adr_q[head_q];
    dn_be_o  = be_q[head_q];
    dn_d_o   = dat_q[head_q];
    if (state_q == S_RD) begin
      dn_adr_o = up_adr_i;
      dn_be_o  = up_be_i;
    end
    up_ack_o = wr_accept || fwd_ack_q || ((state_q == S_RD) && dn_ack_i);
    up_q_o   = fwd_ack_q ? fwd_dat_q : dn_q_i;
    up_err_o = (state_q == S_RD) && dn_ack_i && dn_err_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      adr_q[tail_q] <= up_adr_i;
      be_q[tail_q]  <= up_be_i;
      dat_q[tail_q] <= up_d_i;
    end else if (merge_wr) begin
      be_q[newest_idx]  <= be_q[newest_idx] | up_be_i;
      dat_q[newest_idx] <= mrg_dat;
    end
    if (fwd_go) fwd_dat_q <= dat_q[hit_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fwd_ack_q     <= 1'b0;
      wr_err_q      <= 1'b0;
      drain_done_q  <= 1'b0;
      drain_fired_q <= 1'b0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      count_q       <= count_d;
      fwd_ack_q     <= fwd_go;
      wr_err_q      <= pop && dn_err_i;
      drain_done_q  <= drain_cond;
      drain_fired_q <= drain_i && (drain_fired_q || drain_cond);
    end
  end

  assign wr_err_o     = wr_err_q;
  assign drain_done_o = drain_done_q;
  assign empty_o      = empty;
  assign full_o       = full;

endmodule

// File: tb/tb_riscv_wbuf_fwd.sv
// Directed bench for riscv_wbuf_fwd: vector table plus hand sequences for
// full stall, merging, forwarding, read priority, fence/error and reset.
module tb_riscv_wbuf_fwd;
  localparam int LW = 69;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] d;
    int          exp_lat;
    bit          chk_q;
    logic [31:0] exp_q;
  } vec_t;

  logic        clk, rst;
  logic        up_req, up_we;
  logic [31:0] up_adr, up_d;
  logic [3:0]  up_be;
  logic [31:0] up_q_o;
  logic        up_ack_o, up_err_o;
  logic        dn_req_o, dn_we_o;
  logic [31:0] dn_adr_o, dn_d_o;
  logic [3:0]  dn_be_o;
  logic [31:0] dn_q_i;
  logic        dn_ack_i, dn_err_i;
  logic        drain;
  logic        drain_done_o, wr_err_o, empty_o, full_o;

  logic        resp_ack, resp_err, man_ack;
  int          dn_lat;
  bit          dn_stall;
  logic [31:0] err_adr;
  int          wait_cnt;
  int          log_rd;
  int          total, bad;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] got_q[$];
  vec_t        vecs[8];

  assign dn_ack_i = resp_ack | man_ack;
  assign dn_err_i = resp_err;

  riscv_wbuf_fwd #(.XLEN(32), .DEPTH(4), .FORWARD(1), .MERGE(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .up_req_i(up_req), .up_we_i(up_we), .up_adr_i(up_adr), .up_be_i(up_be), .up_d_i(up_d),
    .up_q_o(up_q_o), .up_ack_o(up_ack_o), .up_err_o(up_err_o),
    .dn_req_o(dn_req_o), .dn_we_o(dn_we_o), .dn_adr_o(dn_adr_o), .dn_be_o(dn_be_o),
    .dn_d_o(dn_d_o), .dn_q_i(dn_q_i), .dn_ack_i(dn_ack_i), .dn_err_i(dn_err_i),
    .drain_i(drain), .drain_done_o(drain_done_o), .wr_err_o(wr_err_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream responder: acks after dn_lat waiting cycles, logs every transfer.
  initial begin
    resp_ack = 1'b0; resp_err = 1'b0; dn_q_i = '0; wait_cnt = 0;
  end
  always @(negedge clk) begin
    if (!dn_stall) begin
      if (resp_ack) begin
        resp_ack = 1'b0;
        resp_err = 1'b0;
      end else if (rst) begin
        wait_cnt = 0;
      end else if (dn_req_o) begin
        if (wait_cnt >= dn_lat) begin
          resp_ack = 1'b1;
          resp_err = dn_we_o && (dn_adr_o == err_adr);
          dn_q_i   = dn_adr_o ^ 32'hCAFE0000;
          got_q.push_back({dn_we_o, dn_adr_o, dn_be_o, dn_we_o ? dn_d_o : 32'h0});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  function automatic logic [LW-1:0] wrec(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    return {1'b1, a, be, d};
  endfunction

  function automatic logic [LW-1:0] rrec(input logic [31:0] a, input logic [3:0] be);
    return {1'b0, a, be, 32'h0};
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name);
    logic [LW-1:0] e;
    check({name, "_count"}, LW'(got_q.size() - log_rd), LW'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (log_rd < got_q.size()) begin
        check(name, got_q[log_rd], e);
        log_rd++;
      end
    end
    log_rd = got_q.size();
  endtask

  // Driver tasks
  task automatic up_access(input bit we, input logic [31:0] adr, input logic [3:0] be,
                           input logic [31:0] d, output int lat, output logic [31:0] q,
                           output logic err);
    @(negedge clk);
    up_req = 1'b1; up_we = we; up_adr = adr; up_be = be; up_d = d;
    lat = 0; q = 'x; err = 'x;
    #1;
    while (!up_ack_o && lat < 400) begin
      @(negedge clk); #1;
      lat++;
    end
    if (up_ack_o) begin
      q = up_q_o;
      err = up_err_o;
    end else begin
      check("ack_timeout", 1, 0);
    end
    @(posedge clk); #1;
    up_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(empty_o && !dn_req_o) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_idle"}, LW'(empty_o && !dn_req_o), 1);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int lat;
    logic [31:0] q;
    logic err;
    for (int i = lo; i <= hi; i++) begin
      up_access(vecs[i].we, vecs[i].adr, vecs[i].be, vecs[i].d, lat, q, err);
      if (vecs[i].exp_lat >= 0) check($sformatf("lat[%0d]", i), LW'(lat), LW'(vecs[i].exp_lat));
      if (vecs[i].chk_q) begin
        check($sformatf("rd_q[%0d]", i), LW'(q), LW'(vecs[i].exp_q));
        check($sformatf("rd_err[%0d]", i), LW'(err), 0);
      end
    end
  endtask

  initial begin
    int lat, lat2, ack_at, err_pulses, done_pulses, err_bad, done_bad, blocked;
    logic [31:0] q, q2;
    logic err, err2, prev_err, ack_with_pop;
    bit acked;

    total = 0; bad = 0; log_rd = 0;
    rst = 1'b1; up_req = 1'b0; up_we = 1'b0; up_adr = '0; up_be = '0; up_d = '0;
    drain = 1'b0; man_ack = 1'b0; dn_lat = 0; dn_stall = 1'b0; err_adr = 32'hFFFFFFFF;

    vecs[0] = '{1'b1, 32'h100, 4'hF, 32'h11110000, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h104, 4'hF, 32'h22220000, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h108, 4'hF, 32'h33330000, 0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h10C, 4'hF, 32'h44440000, 0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 32'h700, 4'hF, 32'h00007000, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h704, 4'hF, 32'h00007004, 0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h708, 4'hF, 32'h00007008, 0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h400, 4'hF, 32'h0, -1, 1'b1, 32'hCAFE0400};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", LW'(empty_o), 1);
    check("rst_full", LW'(full_o), 0);
    check("rst_dn_req", LW'(dn_req_o), 0);
    check("rst_up_ack", LW'(up_ack_o), 0);
    check("rst_wr_err", LW'(wr_err_o), 0);
    check("rst_drain_done", LW'(drain_done_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // In-order drain of four posted writes
    dn_lat = 3;
    run_vecs(0, 3);
    for (int i = 0; i < 4; i++) exp_q.push_back(wrec(vecs[i].adr, vecs[i].be, vecs[i].d));
    wait_idle("seq");
    check_log("seq_order");

    // Full buffer holds the fifth write until the first pop
    dn_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_access(1'b1, 32'h600 + 32'(i * 16), 4'hF, 32'h6000 + 32'(i), lat, q, err);
      check($sformatf("full_wr_lat[%0d]", i), LW'(lat), 0);
      exp_q.push_back(wrec(32'h600 + 32'(i * 16), 4'hF, 32'h6000 + 32'(i)));
    end
    check("full_flag", LW'(full_o), 1);
    @(negedge clk);
    up_req = 1'b1; up_we = 1'b1; up_adr = 32'h640; up_be = 4'hF; up_d = 32'h6004;
    acked = 1'b0; ack_at = -1; ack_with_pop = 1'b0;
    for (int c = 0; c < 60 && !acked; c++) begin
      #1;
      if (up_ack_o) begin
        acked = 1'b1;
        ack_at = c;
        ack_with_pop = dn_ack_i;
      end else begin
        @(negedge clk);
        if (c == 5) begin
          dn_lat = 0;
          dn_stall = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    up_req = 1'b0;
    check("full_5th_acked", LW'(acked), 1);
    check("full_5th_held", LW'(ack_at >= 6), 1);
    check("full_5th_with_pop", LW'(ack_with_pop), 1);
    exp_q.push_back(wrec(32'h640, 4'hF, 32'h6004));
    wait_idle("full");
    check_log("full_order");

    // Merge into newest entry while the head is in flight
    dn_stall = 1'b1;
    up_access(1'b1, 32'h1F0, 4'hF, 32'h01F001F0, lat, q, err);
    up_access(1'b1, 32'h200, 4'b0011, 32'h0000AAAA, lat, q, err);
    up_access(1'b1, 32'h202, 4'b1100, 32'hBBBB0000, lat, q, err);
    check("merge_lat", LW'(lat), 0);
    dn_lat = 1;
    dn_stall = 1'b0;
    exp_q.push_back(wrec(32'h1F0, 4'hF, 32'h01F001F0));
    exp_q.push_back(wrec(32'h200, 4'hF, 32'hBBBBAAAA));
    wait_idle("merge");
    check_log("merge_log");

    // Forwarding: covered read served from the buffer
    dn_stall = 1'b1;
    up_access(1'b1, 32'h2F0, 4'hF, 32'h02F002F0, lat, q, err);
    up_access(1'b1, 32'h300, 4'hF, 32'hDEADBEEF, lat, q, err);
    up_access(1'b0, 32'h300, 4'b0001, 32'h0, lat, q, err);
    check("fwd_lat", LW'(lat), 1);
    check("fwd_q", LW'(q), 32'hDEADBEEF);
    check("fwd_err", LW'(err), 0);
    dn_stall = 1'b0;
    exp_q.push_back(wrec(32'h2F0, 4'hF, 32'h02F002F0));
    exp_q.push_back(wrec(32'h300, 4'hF, 32'hDEADBEEF));
    wait_idle("fwd");
    check_log("fwd_log");

    // Partial cover: read stalls until the entry drains, then goes downstream
    dn_stall = 1'b1;
    up_access(1'b1, 32'h3F0, 4'hF, 32'h03F003F0, lat, q, err);
    up_access(1'b1, 32'h300, 4'b0001, 32'h000000CC, lat, q, err);
    fork
      up_access(1'b0, 32'h300, 4'hF, 32'h0, lat2, q2, err2);
      begin
        repeat (8) @(negedge clk);
        dn_stall = 1'b0;
      end
    join
    check("stall_lat", LW'(lat2 >= 8), 1);
    check("stall_q", LW'(q2), 32'hCAFE0300);
    check("stall_err", LW'(err2), 0);
    exp_q.push_back(wrec(32'h3F0, 4'hF, 32'h03F003F0));
    exp_q.push_back(wrec(32'h300, 4'b0001, 32'h000000CC));
    exp_q.push_back(rrec(32'h300, 4'hF));
    wait_idle("stall");
    check_log("stall_log");

    // Read overtakes buffered writes once the in-flight write completes
    dn_lat = 4;
    run_vecs(4, 7);
    exp_q.push_back(wrec(32'h700, 4'hF, 32'h00007000));
    exp_q.push_back(rrec(32'h400, 4'hF));
    exp_q.push_back(wrec(32'h704, 4'hF, 32'h00007004));
    exp_q.push_back(wrec(32'h708, 4'hF, 32'h00007008));
    wait_idle("prio");
    check_log("prio_order");

    // Fence with a write error on the first entry; up requests blocked
    dn_stall = 1'b1;
    dn_lat = 1;
    err_adr = 32'h800;
    up_access(1'b1, 32'h800, 4'hF, 32'h00000008, lat, q, err);
    up_access(1'b1, 32'h804, 4'hF, 32'h00000084, lat, q, err);
    @(negedge clk);
    drain = 1'b1;
    up_req = 1'b1; up_we = 1'b1; up_adr = 32'h900; up_be = 4'hF; up_d = 32'h9;
    prev_err = 1'b0; err_pulses = 0; done_pulses = 0; err_bad = 0; done_bad = 0; blocked = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) dn_stall = 1'b0;
      #1;
      if (up_ack_o) blocked++;
      if (wr_err_o !== prev_err) err_bad++;
      if (wr_err_o) err_pulses++;
      if (drain_done_o) begin
        done_pulses++;
        if (!empty_o || dn_req_o) done_bad++;
      end
      prev_err = dn_ack_i & dn_err_i & dn_we_o;
    end
    check("drain_blocked_acks", LW'(blocked), 0);
    check("wr_err_pulses", LW'(err_pulses), 1);
    check("wr_err_timing", LW'(err_bad), 0);
    check("drain_done_pulses", LW'(done_pulses), 1);
    check("drain_done_when_idle", LW'(done_bad), 0);
    drain = 1'b0;
    up_req = 1'b0;
    err_adr = 32'hFFFFFFFF;
    exp_q.push_back(wrec(32'h800, 4'hF, 32'h00000008));
    exp_q.push_back(wrec(32'h804, 4'hF, 32'h00000084));
    check_log("drain_log");

    // Fence on an empty, idle buffer pulses the next cycle
    @(negedge clk);
    drain = 1'b1;
    #1;
    check("idle_drain_same", LW'(drain_done_o), 0);
    @(negedge clk); #1;
    check("idle_drain_next", LW'(drain_done_o), 1);
    @(negedge clk); #1;
    check("idle_drain_once", LW'(drain_done_o), 0);
    drain = 1'b0;

    // Reset mid-transfer; the late ack must be ignored
    dn_stall = 1'b1;
    up_access(1'b1, 32'hA00, 4'hF, 32'h00000A00, lat, q, err);
    @(posedge clk); #1;
    check("mid_dn_req", LW'(dn_req_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    man_ack = 1'b1;
    #3;
    check("mid_rst_empty", LW'(empty_o), 1);
    check("mid_rst_dn_req", LW'(dn_req_o), 0);
    check("mid_rst_up_ack", LW'(up_ack_o), 0);
    @(posedge clk); #1;
    man_ack = 1'b0;
    check("mid_rst_wr_err", LW'(wr_err_o), 0);
    check("mid_rst_empty2", LW'(empty_o), 1);
    check("mid_rst_dn_req2", LW'(dn_req_o), 0);
    dn_stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
